tdm_demux4: RTL

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4_if.sv | 19 +
 rtl/tdm_demux4.sv | 73 +++++++
 2 files changed

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial TDM input stream and demultiplexed frame outputs.
interface tdm_demux4_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] o0, o1, o2, o3;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;
  modport master (
    output din, din_valid, sync,
    input  o0, o1, o2, o3, frame_valid, slot, locked, sync_err
  );
  modport slave (
    input  din, din_valid, sync,
    output o0, o1, o2, o3, frame_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM demultiplexer with sync hunting and framing-error detection.
module tdm_demux4 #(parameter int WIDTH = 8) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux4_if.slave  bus
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [2:0][WIDTH-1:0]   sh_q, sh_d;
  logic [3:0][WIDTH-1:0]   o_q, o_d;
  logic                    fv_q, fv_d;
  logic                    se_q, se_d;
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    o_d     = o_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (bus.din_valid) begin
      if (state_q == HUNT) begin
        if (bus.sync) begin
          sh_d[0] = bus.din;
          slot_d  = 2'd1;
          state_d = LOCK;
        end
      end else if (bus.sync) begin
        // an early sync abandons the partial frame and restarts at slot 0
        se_d    = slot_q != 2'd0;
        sh_d[0] = bus.din;
        slot_d  = 2'd1;
      end else if (slot_q == 2'd0) begin
        se_d    = 1'b1;
        slot_d  = 2'd0;
        state_d = HUNT;
      end else if (slot_q == 2'd3) begin
        o_d    = {bus.din, sh_q[2], sh_q[1], sh_q[0]};
        fv_d   = 1'b1;
        slot_d = 2'd0;
      end else begin
        if (slot_q == 2'd1) sh_d[1] = bus.din;
        else sh_d[2] = bus.din;
        slot_d = slot_q + 2'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      sh_q    <= '0;
      o_q     <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
      o_q     <= o_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end
  assign bus.o0          = o_q[0];
  assign bus.o1          = o_q[1];
  assign bus.o2          = o_q[2];
  assign bus.o3          = o_q[3];
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = se_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = state_q == LOCK;
endmodule
